io_pad_bank: RTL and testbench

Parametrised GPIO bank sitting between the SoC bus and a row of bidirectional pad cells. It replaces direct core-to-pad GPIO wiring with a register-programmed channel array. Per channel it provides output data and drive enable, a multi-stage input synchroniser, optional debounce, and rising/falling-edge interrupt capture. It drives the pad cells' I and active-low OEN pins and samples their C pins.

---
 rtl/io_pad_bank.sv | 166 ++++++++++++++++
 tb/tb_io_pad_bank.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_pad_bank.sv
// io_pad_bank: register-programmed GPIO channel bank driving bidirectional pad cells.
// Define IO_BANK_DEBOUNCE_EN to build the debounce prescaler and debounce stage.
module io_pad_bank #(
   parameter int NUM_IO      = 32,
   parameter int SYNC_STAGES = 2,
   parameter int DEBOUNCE_W  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              reg_we,
   input  logic              reg_re,
   input  logic [2:0]        reg_addr,
   input  logic [31:0]       reg_wdata,
   output logic [31:0]       reg_rdata,
   output logic              reg_ack,
   input  logic [NUM_IO-1:0] pad_c_i,
   output logic [NUM_IO-1:0] pad_i_o,
   output logic [NUM_IO-1:0] pad_oen_o,
   output logic              irq_o
);

   logic [NUM_IO-1:0] wd;
   logic              wr_dout;
   logic              wr_oen;
   logic              wr_ien;
   logic              wr_ren;
   logic              wr_fen;
   logic              wr_clr;

   logic [NUM_IO-1:0] dout_q;
   logic [NUM_IO-1:0] oen_q;
   logic [NUM_IO-1:0] ien_q;
   logic [NUM_IO-1:0] ren_q;
   logic [NUM_IO-1:0] fen_q;
   logic [NUM_IO-1:0] status_q;

   logic [NUM_IO-1:0] sync_q [SYNC_STAGES];
   logic [NUM_IO-1:0] s;
   logic [NUM_IO-1:0] deb;
   logic [NUM_IO-1:0] deb_prev;
   logic [NUM_IO-1:0] edge_set;
   logic [31:0]       rd_val;

   assign wd      = reg_wdata[NUM_IO-1:0];
   assign wr_dout = reg_we && (reg_addr == 3'd0);
   assign wr_oen  = reg_we && (reg_addr == 3'd1);
   assign wr_ien  = reg_we && (reg_addr == 3'd3);
   assign wr_ren  = reg_we && (reg_addr == 3'd4);
   assign wr_fen  = reg_we && (reg_addr == 3'd5);
   assign wr_clr  = reg_we && (reg_addr == 3'd6);

   // Input synchroniser chain; s is the last stage
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      end else begin
         sync_q[0] <= pad_c_i;
         for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      end
   end

   assign s = sync_q[SYNC_STAGES-1];

`ifdef IO_BANK_DEBOUNCE_EN
   logic [DEBOUNCE_W-1:0] cnt_q;
   logic [DEBOUNCE_W-1:0] limit_q;
   logic [NUM_IO-1:0]     samp_q;
   logic [NUM_IO-1:0]     deb_q;
   logic                  tick;
   logic                  wr_lim;

   assign wr_lim = reg_we && (reg_addr == 3'd7);
   assign tick   = (cnt_q == limit_q);

   // Shared prescaler; a limit write restarts the tick phase
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q   <= '0;
         limit_q <= '0;
      end else if (wr_lim) begin
         cnt_q   <= '0;
         limit_q <= reg_wdata[DEBOUNCE_W-1:0];
      end else if (tick) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   // deb follows s once two consecutive ticks saw the same value
   always_ff @(posedge clk) begin
      if (reset) begin
         samp_q <= '0;
         deb_q  <= '0;
      end else if (tick) begin
         samp_q <= s;
         for (int i = 0; i < NUM_IO; i++)
            if (s[i] == samp_q[i]) deb_q[i] <= s[i];
      end
   end

   assign deb = deb_q;
`else
   assign deb = s;
`endif

   assign edge_set = (deb & ~deb_prev & ren_q) |
                     (~deb & deb_prev & fen_q);

   // Control registers and sticky status; a new edge beats a W1C
   always_ff @(posedge clk) begin
      if (reset) begin
         dout_q   <= '0;
         oen_q    <= '0;
         ien_q    <= '0;
         ren_q    <= '0;
         fen_q    <= '0;
         status_q <= '0;
         deb_prev <= '0;
      end else begin
         if (wr_dout) dout_q <= wd;
         if (wr_oen)  oen_q  <= wd;
         if (wr_ien)  ien_q  <= wd;
         if (wr_ren)  ren_q  <= wd;
         if (wr_fen)  fen_q  <= wd;
         status_q <= (status_q & ~(wr_clr ? wd : '0)) | edge_set;
         deb_prev <= deb;
      end
   end

   // Read mux on current state, so a combined read+write returns old data
   always_comb begin
      rd_val = '0;
      case (reg_addr)
         3'd0: rd_val[NUM_IO-1:0] = dout_q;
         3'd1: rd_val[NUM_IO-1:0] = oen_q;
         3'd2: rd_val[NUM_IO-1:0] = deb;
         3'd3: rd_val[NUM_IO-1:0] = ien_q;
         3'd4: rd_val[NUM_IO-1:0] = ren_q;
         3'd5: rd_val[NUM_IO-1:0] = fen_q;
         3'd6: rd_val[NUM_IO-1:0] = status_q;
`ifdef IO_BANK_DEBOUNCE_EN
         3'd7: rd_val[DEBOUNCE_W-1:0] = limit_q;
`else
         3'd7: rd_val = '0;
`endif
         default: rd_val = '0;
      endcase
   end

   // Registered acknowledge and read data, zero outside an ack
   always_ff @(posedge clk) begin
      if (reset) begin
         reg_ack   <= 1'b0;
         reg_rdata <= '0;
      end else begin
         reg_ack   <= reg_we | reg_re;
         reg_rdata <= reg_re ? rd_val : 32'd0;
      end
   end

   assign pad_i_o   = dout_q;
   assign pad_oen_o = ~oen_q;
   assign irq_o     = |(status_q & ien_q);

endmodule

// File: tb/tb_io_pad_bank.sv
// tb_io_pad_bank: directed and randomized checks of io_pad_bank.
// Covers both builds; IO_BANK_DEBOUNCE_EN selects debounce expectations.
module tb_io_pad_bank;

   localparam int SYNC = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        reg_we = 1'b0;
   logic        reg_re = 1'b0;
   logic [2:0]  reg_addr = '0;
   logic [31:0] reg_wdata = '0;
   logic [31:0] reg_rdata;
   logic        reg_ack;
   logic [31:0] pad_c = '0;
   logic [31:0] pad_i;
   logic [31:0] pad_oen;
   logic        irq;

   logic        we8 = 1'b0;
   logic        re8 = 1'b0;
   logic [2:0]  addr8 = '0;
   logic [31:0] wdata8 = '0;
   logic [31:0] rdata8;
   logic        ack8;
   logic [7:0]  pad_c8 = '0;
   logic [7:0]  pad_i8;
   logic [7:0]  pad_oen8;
   logic        irq8;

   int n_pass = 0;
   int n_fail = 0;
   int n_total = 0;

   io_pad_bank #(.NUM_IO(32), .SYNC_STAGES(SYNC), .DEBOUNCE_W(8)) dut (
      .clk(clk), .reset(reset), .reg_we(reg_we), .reg_re(reg_re),
      .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
      .reg_ack(reg_ack), .pad_c_i(pad_c), .pad_i_o(pad_i),
      .pad_oen_o(pad_oen), .irq_o(irq)
   );

   io_pad_bank #(.NUM_IO(8), .SYNC_STAGES(SYNC), .DEBOUNCE_W(8)) dut8 (
      .clk(clk), .reset(reset), .reg_we(we8), .reg_re(re8),
      .reg_addr(addr8), .reg_wdata(wdata8), .reg_rdata(rdata8),
      .reg_ack(ack8), .pad_c_i(pad_c8), .pad_i_o(pad_i8),
      .pad_oen_o(pad_oen8), .irq_o(irq8)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic access(input logic we, input logic re,
                         input logic [2:0] a, input logic [31:0] d,
                         output logic [31:0] rd, output logic ack);
      reg_we = we;
      reg_re = re;
      reg_addr = a;
      reg_wdata = d;
      tick();
      reg_we = 1'b0;
      reg_re = 1'b0;
      rd = reg_rdata;
      ack = reg_ack;
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      logic [31:0] rd;
      logic ack;
      access(1'b1, 1'b0, a, d, rd, ack);
   endtask

   task automatic rd(input logic [2:0] a, output logic [31:0] v);
      logic ack;
      access(1'b0, 1'b1, a, 32'd0, v, ack);
   endtask

   // Reference model state
   logic [31:0] m_reg [8];
   logic [31:0] m_status;
   logic [31:0] v;
   logic        a;
   logic [31:0] old_p;
   logic [31:0] new_p;
   logic [31:0] msk;
   int          lim;
   int          k;
   bit          seen;
   logic [2:0]  ra;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      repeat (3) tick();
      reset = 1'b0;

      chk("rst_oen", pad_oen, 32'hFFFF_FFFF);
      chk("rst_pad_i", pad_i, 32'h0);
      chk("rst_irq", {31'd0, irq}, 32'd0);
      chk("rst_ack", {31'd0, reg_ack}, 32'd0);
      chk("rst_rdata", reg_rdata, 32'd0);
      access(1'b0, 1'b1, 3'd2, 32'd0, v, a);
      chk("rst_data_in", v, 32'd0);
      chk("rst_read_ack", {31'd0, a}, 32'd1);
      tick();
      chk("ack_drops", {31'd0, reg_ack}, 32'd0);
      rd(3'd7, v);
      chk("rst_limit", v, 32'd0);

      wr(3'd1, 32'h0000_00F0);
      chk("oen_next_cycle", pad_oen, 32'hFFFF_FF0F);
      wr(3'd0, 32'h0000_00A0);
      chk("dout_next_cycle", pad_i, 32'h0000_00A0);
      access(1'b1, 1'b1, 3'd0, 32'h0000_0055, v, a);
      chk("rw_pre_value", v, 32'h0000_00A0);
      chk("rw_ack", {31'd0, a}, 32'd1);
      rd(3'd0, v);
      chk("rw_new_value", v, 32'h0000_0055);
      wr(3'd2, 32'hFFFF_FFFF);
      rd(3'd2, v);
      chk("data_in_ro", v, 32'd0);

`ifdef IO_BANK_DEBOUNCE_EN
      wr(3'd7, 32'd3);
      pad_c[0] = 1'b1;
      repeat (SYNC + 8) tick();
      rd(3'd2, v);
      chk("deb_rise", v, 32'd1);
      pad_c[0] = 1'b0;
      rd(3'd2, v);
      chk("glitch_a", v, 32'd1);
      rd(3'd2, v);
      chk("glitch_b", v, 32'd1);
      pad_c[0] = 1'b1;
      for (int i = 0; i < 10; i++) begin
         rd(3'd2, v);
         chk("glitch_hold", v, 32'd1);
      end
      rd(3'd7, v);
      chk("limit_rb", v, 32'd3);
`else
      pad_c[0] = 1'b1;
      repeat (SYNC - 1) tick();
      rd(3'd2, v);
      chk("sync_lat_before", v, 32'd0);
      rd(3'd2, v);
      chk("sync_lat_at", v, 32'd1);
      wr(3'd7, 32'd3);
      rd(3'd7, v);
      chk("limit_absent", v, 32'd0);
`endif

      wr(3'd6, 32'hFFFF_FFFF);
      wr(3'd5, 32'd0);
      wr(3'd4, 32'h20);
      wr(3'd3, 32'h20);
      wr(3'd7, 32'd0);
      pad_c[5] = 1'b1;
      k = 0;
      seen = 1'b0;
      for (int i = 1; i <= 30; i++) begin
         tick();
         if (irq === 1'b1) begin
            k = i;
            seen = 1'b1;
            break;
         end
      end
      chk("irq_rise_seen", {31'd0, seen}, 32'd1);
      chk("irq_lat_bound", {31'd0, (k <= SYNC + 4)}, 32'd1);
      rd(3'd6, v);
      chk("status_rise5", v, 32'h20);
      wr(3'd6, 32'd0);
      rd(3'd6, v);
      chk("w1c_zero", v, 32'h20);
      wr(3'd6, 32'h20);
      chk("irq_cleared", {31'd0, irq}, 32'd0);

      pad_c[5] = 1'b0;
      repeat (10) tick();
      rd(3'd6, v);
      chk("fall_disabled", v, 32'd0);
      wr(3'd7, 32'd0);
      pad_c[5] = 1'b1;
      if (k > 1) repeat (k - 1) tick();
      wr(3'd6, 32'h20);
      rd(3'd6, v);
      chk("set_beats_clear", v, 32'h20);
      wr(3'd6, 32'h20);
      rd(3'd6, v);
      chk("clear_after", v, 32'd0);

      // Randomized phase against a register/edge model
      for (int r = 0; r < 8; r++) m_reg[r] = '0;
      m_status = '0;
      old_p = pad_c;
      for (int it = 0; it < 30; it++) begin
         lim = $urandom_range(0, 3);
         wr(3'd7, lim);
`ifdef IO_BANK_DEBOUNCE_EN
         m_reg[7] = lim;
`else
         m_reg[7] = 0;
`endif
         for (int r = 0; r < 6; r++) begin
            if (r != 2) begin
               m_reg[r] = $urandom;
               wr(r[2:0], m_reg[r]);
            end
         end
         chk("rnd_pad_i", pad_i, m_reg[0]);
         chk("rnd_oen", pad_oen, ~m_reg[1]);
         wr(3'd2, $urandom);
         new_p = $urandom;
         pad_c = new_p;
         m_status = m_status | (new_p & ~old_p & m_reg[4])
                             | (~new_p & old_p & m_reg[5]);
         old_p = new_p;
         repeat (SYNC + 2 * (lim + 1) + 4) tick();
         rd(3'd2, v);
         chk("rnd_data_in", v, new_p);
         rd(3'd6, v);
         chk("rnd_status", v, m_status);
         chk("rnd_irq", {31'd0, irq}, {31'd0, |(m_status & m_reg[3])});
         ra = 3'($urandom_range(0, 7));
         if (ra == 3'd2 || ra == 3'd6) ra = 3'd7;
         rd(ra, v);
         chk("rnd_readback", v, m_reg[ra]);
         msk = $urandom;
         wr(3'd6, msk);
         m_status = m_status & ~msk;
      end
      rd(3'd6, v);
      chk("rnd_status_end", v, m_status);

      we8 = 1'b1;
      addr8 = 3'd1;
      wdata8 = 32'hFFFF_FFFF;
      tick();
      we8 = 1'b0;
      re8 = 1'b1;
      tick();
      re8 = 1'b0;
      chk("n8_readback", rdata8, 32'h0000_00FF);
      chk("n8_oen", {24'd0, pad_oen8}, 32'd0);

      pad_c = 32'hFFFF_FFFF;
      wr(3'd4, 32'hFFFF_FFFF);
      wr(3'd3, 32'hFFFF_FFFF);
      repeat (12) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mid_rst_oen", pad_oen, 32'hFFFF_FFFF);
      chk("mid_rst_irq", {31'd0, irq}, 32'd0);
      rd(3'd2, v);
      chk("mid_rst_sync", v, 32'd0);
      rd(3'd6, v);
      chk("mid_rst_status", v, 32'd0);
      rd(3'd1, v);
      chk("mid_rst_outen", v, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
